mix_freq_seq: RTL and testbench

//  Measurement sequencer for the multi-channel mixer (mix_freq_mc). Resyncs the mixer, skips settle

---
 rtl/mix_freq_pkg.sv | 27 ++
 rtl/mix_freq_seq_if.sv | 15 +
 rtl/mix_seq_serializer.sv | 71 +++++++
 rtl/mix_freq_seq.sv | 158 +++++++++++++++
 tb/tb_mix_freq_seq.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mix_freq_pkg.sv
// Shared types and constants for the mixer measurement sequencer.
// Status word layout: {cycle[15:0], sin_phase, sin_addr[14:0]}.
package mix_freq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StSettle,
    StArm,
    StDrain
  } seq_state_e;

  localparam int unsigned CHANNEL_DEF     = 8;
  localparam int unsigned WORDS_PER_FRAME = 2 * CHANNEL_DEF;

  localparam int unsigned ADDR_LSB  = 0;
  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned PHASE_BIT = 15;
  localparam int unsigned CYCLE_LSB = 16;

  // Accumulator-clear boundary: first table address, positive half, matching cycle count.
  function automatic logic is_boundary(input logic [31:0] status, input logic [15:0] cycle_num);
    return (status[ADDR_LSB +: ADDR_W] == 15'd1) && !status[PHASE_BIT] &&
           (status[CYCLE_LSB +: 16] == cycle_num);
  endfunction

endpackage

// File: rtl/mix_freq_seq_if.sv
// Result word stream from the sequencer to the result DMA.
interface mix_freq_seq_if;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_sop;
  logic        res_eop;

  modport master (output res_valid, output res_data, output res_sop, output res_eop,
                  input res_ready);
  modport slave  (input res_valid, input res_data, input res_sop, input res_eop,
                  output res_ready);

endinterface

// File: rtl/mix_seq_serializer.sv
// Snapshot bank for all channels' I/Q accumulators, streamed out as I0,Q0,I1,Q1,...
// with a valid/ready handshake. Requires CHANNEL >= 2.
module mix_seq_serializer
  import mix_freq_pkg::*;
#(
  parameter int unsigned CHANNEL = CHANNEL_DEF
) (
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   load,
  input  logic [32*CHANNEL-1:0]  i_acc,
  input  logic [32*CHANNEL-1:0]  q_acc,
  input  logic                   ready,
  output logic                   valid,
  output logic [31:0]            data,
  output logic                   sop,
  output logic                   eop,
  output logic                   busy,
  output logic                   last
);

  localparam int unsigned CW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;

  logic [31:0]   snap_i_q [CHANNEL];
  logic [31:0]   snap_q_q [CHANNEL];
  logic [CW-1:0] ch_q;
  logic          iq_q;
  logic          valid_q;
  logic          at_last;

  assign at_last = (ch_q == CW'(CHANNEL - 1)) && iq_q;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < int'(CHANNEL); c++) begin
        snap_i_q[c] <= '0;
        snap_q_q[c] <= '0;
      end
      ch_q    <= '0;
      iq_q    <= 1'b0;
      valid_q <= 1'b0;
    end else if (load) begin
      for (int c = 0; c < int'(CHANNEL); c++) begin
        snap_i_q[c] <= i_acc[32*c +: 32];
        snap_q_q[c] <= q_acc[32*c +: 32];
      end
      ch_q    <= '0;
      iq_q    <= 1'b0;
      valid_q <= 1'b1;
    end else if (valid_q && ready) begin
      if (at_last) begin
        valid_q <= 1'b0;
      end else begin
        iq_q <= ~iq_q;
        if (iq_q) ch_q <= ch_q + 1'b1;
      end
    end
  end

  always_comb begin
    data = '0;
    if (valid_q) data = iq_q ? snap_q_q[ch_q] : snap_i_q[ch_q];
  end

  assign valid = valid_q;
  assign busy  = valid_q;
  assign sop   = valid_q && (ch_q == '0) && !iq_q;
  assign eop   = valid_q && at_last;
  assign last  = valid_q && at_last;

endmodule

// File: rtl/mix_freq_seq.sv
// Measurement sequencer: resyncs the mixer, skips settle frames, then snapshots and streams
// every channel's I/Q accumulators at each accumulator-clear boundary.
module mix_freq_seq
  import mix_freq_pkg::*;
#(
  parameter int unsigned CHANNEL = CHANNEL_DEF,
  parameter int unsigned FCW     = 16
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [FCW-1:0]        frame_cnt,
  input  logic [3:0]            settle_frames,
  input  logic [15:0]           cycle_num,
  input  logic [31:0]           status,
  input  logic [32*CHANNEL-1:0] ipcm_acc_out,
  input  logic [32*CHANNEL-1:0] qpcm_acc_out,
  output logic                  resync,
  mix_freq_seq_if.master        res,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [FCW-1:0]        frame_idx
);

  seq_state_e     state_q, state_d;
  logic           bnd_q, bnd_d;
  logic           sync_cnt_q, sync_cnt_d;
  logic [3:0]     settle_cnt_q, settle_cnt_d;
  logic [FCW-1:0] frame_idx_q, frame_idx_d;
  logic           overrun_q, overrun_d;
  logic           done_q, done_d;
  logic           stop_pend_q, stop_pend_d;

  logic           bnd, bnd_edge, load, eop_acc, ser_busy, ser_last;
  logic [FCW-1:0] frame_idx_inc;

  assign bnd           = is_boundary(status, cycle_num);
  assign bnd_edge      = bnd && !bnd_q;
  assign eop_acc       = res.res_valid && res.res_ready && ser_last;
  assign frame_idx_inc = frame_idx_q + 1'b1;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      bnd_q        <= 1'b0;
      sync_cnt_q   <= 1'b0;
      settle_cnt_q <= '0;
      frame_idx_q  <= '0;
      overrun_q    <= 1'b0;
      done_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bnd_q        <= bnd_d;
      sync_cnt_q   <= sync_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      frame_idx_q  <= frame_idx_d;
      overrun_q    <= overrun_d;
      done_q       <= done_d;
      stop_pend_q  <= stop_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sync_cnt_d   = sync_cnt_q;
    settle_cnt_d = settle_cnt_q;
    frame_idx_d  = frame_idx_q;
    overrun_d    = overrun_q;
    stop_pend_d  = stop_pend_q;
    done_d       = 1'b0;
    load         = 1'b0;
    // Edge history is forgotten before settling so a boundary already high counts once.
    bnd_d        = (state_q == StIdle || state_q == StSync) ? 1'b0 : bnd;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d      = StSync;
          sync_cnt_d   = 1'b0;
          settle_cnt_d = '0;
          frame_idx_d  = '0;
          overrun_d    = 1'b0;
          stop_pend_d  = 1'b0;
        end
      end
      StSync: begin
        if (stop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (sync_cnt_q) begin
          state_d = (settle_frames == 4'd0) ? StArm : StSettle;
        end else begin
          sync_cnt_d = 1'b1;
        end
      end
      StSettle: begin
        if (stop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (bnd_edge) begin
          settle_cnt_d = settle_cnt_q + 4'd1;
          if (settle_cnt_d == settle_frames) state_d = StArm;
        end
      end
      StArm: begin
        if (stop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (bnd_edge) begin
          load    = 1'b1;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (stop) stop_pend_d = 1'b1;
        // A boundary while draining drops that frame; the snapshot is left untouched.
        if (bnd_edge) overrun_d = 1'b1;
        if (eop_acc) begin
          frame_idx_d = frame_idx_inc;
          if (stop_pend_q || stop || (frame_cnt != '0 && frame_idx_inc == frame_cnt)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StArm;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  mix_seq_serializer #(
    .CHANNEL (CHANNEL)
  ) u_ser (
    .clk1  (clk1),
    .rst   (rst),
    .load  (load),
    .i_acc (ipcm_acc_out),
    .q_acc (qpcm_acc_out),
    .ready (res.res_ready),
    .valid (res.res_valid),
    .data  (res.res_data),
    .sop   (res.res_sop),
    .eop   (res.res_eop),
    .busy  (ser_busy),
    .last  (ser_last)
  );

  assign resync    = (state_q == StSync);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign frame_idx = frame_idx_q;

endmodule

// File: tb/tb_mix_freq_seq.sv
// Scoreboard bench for mix_freq_seq with two channels: expected words are queued when a
// capturing boundary is driven and compared as the sink accepts them.
module tb_mix_freq_seq;

  localparam int unsigned CH  = 2;
  localparam int unsigned FCW = 16;
  localparam logic [15:0] CYC = 16'h1234;
  localparam logic [31:0] BND = {CYC, 1'b0, 15'd1};

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } exp_t;

  logic            clk1, rst, start, stop;
  logic [FCW-1:0]  frame_cnt;
  logic [3:0]      settle_frames;
  logic [15:0]     cycle_num;
  logic [31:0]     status;
  logic [32*CH-1:0] ipcm, qpcm;
  logic            resync, busy, done, overrun;
  logic [FCW-1:0]  frame_idx;
  logic            toggle_en;

  mix_freq_seq_if rif ();

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mix_freq_seq #(
    .CHANNEL (CH),
    .FCW     (FCW)
  ) dut (
    .clk1          (clk1),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .frame_cnt     (frame_cnt),
    .settle_frames (settle_frames),
    .cycle_num     (cycle_num),
    .status        (status),
    .ipcm_acc_out  (ipcm),
    .qpcm_acc_out  (qpcm),
    .resync        (resync),
    .res           (rif.master),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun),
    .frame_idx     (frame_idx)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    idle(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    idle(1);
    stop = 1'b0;
  endtask

  // One-cycle status value; when cap is set the resulting frame is queued as expected output.
  task automatic pulse_bnd(input logic [31:0] st, input logic [31:0] i0, input logic [31:0] q0,
                           input logic [31:0] i1, input logic [31:0] q1, input bit cap);
    ipcm   = {i1, i0};
    qpcm   = {q1, q0};
    status = st;
    if (cap) begin
      sb.push_back('{data: i0, sop: 1'b1, eop: 1'b0});
      sb.push_back('{data: q0, sop: 1'b0, eop: 1'b0});
      sb.push_back('{data: i1, sop: 1'b0, eop: 1'b0});
      sb.push_back('{data: q1, sop: 1'b0, eop: 1'b1});
    end
    idle(1);
    status = 32'h0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge clk1);
      n++;
    end while (!done && n < 200);
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    if (done) begin
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      @(negedge clk1);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk1);
      #1;
      if (toggle_en) rif.res_ready = ~rif.res_ready;
    end
  end

  // Sink-side monitor: compares accepted words and holds stalled words steady.
  logic        stall_q = 1'b0;
  logic [31:0] held    = '0;
  always @(negedge clk1) begin
    exp_t e;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && rif.res_valid) check("stall_hold", rif.res_data, held);
      if (rif.res_valid && rif.res_ready) begin
        e = (sb.size() > 0) ? sb.pop_front() : '{data: 'x, sop: 'x, eop: 'x};
        check("word_data", rif.res_data, e.data);
        check("word_sop", 32'(rif.res_sop), 32'(e.sop));
        check("word_eop", 32'(rif.res_eop), 32'(e.eop));
      end
      stall_q = rif.res_valid && !rif.res_ready;
      held    = rif.res_data;
    end
  end

  initial begin
    int rs;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    frame_cnt = '0;
    settle_frames = '0;
    cycle_num = CYC;
    status = '0;
    ipcm = '0;
    qpcm = '0;
    toggle_en = 1'b0;
    rif.res_ready = 1'b1;
    idle(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(rif.res_valid), 0);
    check("rst_resync", 32'(resync), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_frame_idx", 32'(frame_idx), 0);
    rst = 1'b0;
    idle(2);

    // 1: single frame, no settle, resync width, latency
    frame_cnt = 1;
    settle_frames = 0;
    pulse_start();
    rs = 0;
    repeat (5) begin
      @(negedge clk1);
      if (resync) rs++;
    end
    check("t1_resync_cycles", 32'(rs), 2);
    idle(1);
    pulse_bnd(BND, 32'h11, 32'h22, 32'h33, 32'h44, 1'b1);
    @(negedge clk1);
    check("t1_latency_valid", 32'(rif.res_valid), 1);
    wait_done("t1");
    check("t1_frame_idx", 32'(frame_idx), 1);
    check("t1_sb_empty", 32'(sb.size()), 0);

    // 2: three settle boundaries, non-boundary status, then two frames
    frame_cnt = 2;
    settle_frames = 3;
    pulse_start();
    idle(4);
    for (int k = 0; k < 3; k++) begin
      pulse_bnd(BND, 32'hdead0000 + k, 32'h1, 32'h2, 32'h3, 1'b0);
      idle(3);
    end
    pulse_bnd({CYC, 1'b1, 15'd1}, 32'hbad1, 32'hbad2, 32'hbad3, 32'hbad4, 1'b0);
    idle(3);
    pulse_bnd({CYC ^ 16'h1, 1'b0, 15'd1}, 32'hbad5, 32'hbad6, 32'hbad7, 32'hbad8, 1'b0);
    idle(3);
    pulse_bnd(BND, 32'ha0, 32'ha1, 32'ha2, 32'ha3, 1'b1);
    idle(8);
    pulse_bnd(BND, 32'hb0, 32'hb1, 32'hb2, 32'hb3, 1'b1);
    wait_done("t2");
    check("t2_frame_idx", 32'(frame_idx), 2);
    check("t2_sb_empty", 32'(sb.size()), 0);

    // 3: sink toggling ready every cycle
    frame_cnt = 1;
    settle_frames = 0;
    pulse_start();
    idle(4);
    toggle_en = 1'b1;
    pulse_bnd(BND, 32'hc0c0_0001, 32'hc0c0_0002, 32'hc0c0_0003, 32'hc0c0_0004, 1'b1);
    wait_done("t3");
    toggle_en = 1'b0;
    idle(1);
    rif.res_ready = 1'b1;
    check("t3_sb_empty", 32'(sb.size()), 0);

    // 4: continuous mode, stalled across a boundary, then stop in ARM
    frame_cnt = 0;
    pulse_start();
    idle(4);
    rif.res_ready = 1'b0;
    pulse_bnd(BND, 32'hd0, 32'hd1, 32'hd2, 32'hd3, 1'b1);
    idle(3);
    pulse_bnd(BND, 32'he0, 32'he1, 32'he2, 32'he3, 1'b0);
    @(negedge clk1);
    check("t4_overrun", 32'(overrun), 1);
    check("t4_idx_after_drop", 32'(frame_idx), 0);
    idle(1);
    rif.res_ready = 1'b1;
    idle(6);
    check("t4_idx_after_drain", 32'(frame_idx), 1);
    pulse_bnd(BND, 32'hf0, 32'hf1, 32'hf2, 32'hf3, 1'b1);
    idle(6);
    check("t4_idx_after_next", 32'(frame_idx), 2);
    pulse_stop();
    @(negedge clk1);
    check("t4_stop_arm_done", 32'(done), 1);
    check("t4_stop_arm_busy", 32'(busy), 0);
    check("t4_overrun_sticky", 32'(overrun), 1);
    check("t4_sb_empty", 32'(sb.size()), 0);

    // 5: stop mid-frame lets the frame finish
    pulse_start();
    @(negedge clk1);
    check("t5_overrun_cleared", 32'(overrun), 0);
    idle(3);
    rif.res_ready = 1'b0;
    pulse_bnd(BND, 32'h5a0, 32'h5a1, 32'h5a2, 32'h5a3, 1'b1);
    rif.res_ready = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    rif.res_ready = 1'b0;
    pulse_stop();
    @(negedge clk1);
    check("t5_busy_after_stop", 32'(busy), 1);
    check("t5_done_early", 32'(done), 0);
    idle(1);
    rif.res_ready = 1'b1;
    wait_done("t5");
    check("t5_frame_idx", 32'(frame_idx), 1);
    check("t5_sb_empty", 32'(sb.size()), 0);

    // 6: asynchronous reset mid-drain, then a clean frame
    frame_cnt = 1;
    pulse_start();
    idle(3);
    rif.res_ready = 1'b0;
    pulse_bnd(BND, 32'h600, 32'h601, 32'h602, 32'h603, 1'b1);
    idle(1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(rif.res_valid), 0);
    check("t6_rst_data", rif.res_data, 0);
    check("t6_rst_sop", 32'(rif.res_sop), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_frame_idx", 32'(frame_idx), 0);
    sb.delete();
    idle(2);
    rst = 1'b0;
    rif.res_ready = 1'b1;
    idle(1);
    pulse_start();
    idle(3);
    pulse_bnd(BND, 32'h700, 32'h701, 32'h702, 32'h703, 1'b1);
    wait_done("t6");
    check("t6_overrun", 32'(overrun), 0);
    check("t6_frame_idx", 32'(frame_idx), 1);
    check("t6_sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
